vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Text-mode pixel source: 80x30 characters, 8x16 glyphs, 640x480.
- Sits directly upstream of the VGA timing controller and consumes its h_addr/v_addr/valid/hsync/vsync.
- Fetches character codes from an external synchronous char RAM and glyph rows from an external synchronous font ROM, then produces 24-bit vga_data.
- Also outputs hsync/vsync/valid delayed to match its pipeline latency. The top level drives the pads from these delayed signals.

Parameters:
- BLINK_FRAMES, 30, frames per cursor blink phase (range 1..255).
- FG_COLOR, 24'hAAAAAA, foreground colour when attributes are compiled out.
- BG_COLOR, 24'h000000, background colour when attributes are compiled out.

Ports:
- pclk  in  1  pixel clock, 25 MHz.
- reset_n  in  1  asynchronous reset, active-low.
- h_addr  in  10  pixel column, 0..639.
- v_addr  in  10  pixel row, 0..479.
- valid_i  in  1  active-video flag from the timing controller.
- hsync_i  in  1  horizontal sync from the timing controller.
- vsync_i  in  1  vertical sync from the timing controller; low = sync pulse.
- cur_x  in  7  cursor column, 0..79.
- cur_y  in  5  cursor row, 0..29.
- char_addr  out  12  char RAM read address.
- char_data  in  16  char RAM data, returned 1 cycle after address.
- font_addr  out  12  font ROM read address.
- font_data  in  8  font ROM data, returned 1 cycle after address; bit7 = leftmost pixel.
- hsync_o  out  1  hsync delayed by 4 cycles.
- vsync_o  out  1  vsync delayed by 4 cycles.
- valid_o  out  1  valid delayed by 4 cycles.
- vga_data  out  24  {R,G,B} colour of the pixel.

Behaviour:
- Reset values: char_addr=0, font_addr=0, vga_data=0, valid_o=0, hsync_o=1, vsync_o=1. All internal pipeline registers are cleared to the same inactive values. Blink counter=0, blink_on=1.
- Reset is asynchronous both in assertion and effect. Deassertion mid-frame resumes at the next pixel; no recovery state is needed.
- Fixed latency 4: vga_data/valid_o/hsync_o/vsync_o at cycle t+4 correspond to inputs sampled at t.
- S1 (edge t+1):
  - col=h_addr[9:3], row=v_addr[8:4].
  - char_addr <= row*80 + col, computed as (row<<6)+(row<<4)+col in 12 bits; maximum 2399.
  - Register glyph_row=v_addr[3:0], px=h_addr[2:0], cursor_hit=(col==cur_x)&(row==cur_y), and valid/hsync/vsync.
- S2: char_data is valid.
  - font_addr <= {char_data[7:0], glyph_row}, registered.
  - Carry attribute bits, px, cursor_hit and syncs forward.
- S3: font_data is valid.
  - bit = font_data[7-px].
  - Carry fg/bg and syncs forward.
- S4 (output register):
  - inv = cursor_hit & blink_on & (glyph_row>=14).
  - vga_data <= !valid ? 0 : ((bit ^ inv) ? fg : bg).
- Blanking: vga_data is 0 whenever the delayed valid is 0, regardless of char/font data.
- Inputs outside range (h_addr>=640 or v_addr>=480) only occur with valid_i=0. Addresses are still issued; output stays black.
- Blink:
  - Frame start = rising edge of vsync_i, detected with one register holding the previous vsync_i (reset value 1).
  - On each frame start, the counter increments. At BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - With BLINK_FRAMES=1, blink_on toggles every frame.
- cur_x/cur_y are sampled every cycle with no synchronisation. A change takes effect on the next pixel compared.

Optional Feature:
- Macro: VGA_TEXT_ATTR_COLOR_EN.
- Defined:
  - char_data[11:8] = fg index, char_data[15:12] = bg index.
  - Indices map through a fixed CGA palette: 0 000000, 1 0000AA, 2 00AA00, 3 00AAAA, 4 AA0000, 5 AA00AA, 6 AA5500, 7 AAAAAA, 8 555555, 9 5555FF, 10 55FF55, 11 55FFFF, 12 FF5555, 13 FF55FF, 14 FFFF55, 15 FFFFFF.
  - The palette lookup is combinational from registered indices in S3. Latency stays 4.
- Undefined:
  - char_data[15:8] is ignored; fg=FG_COLOR, bg=BG_COLOR.
  - Port list is unchanged.

Test Plan:
- Address generation: h_addr=639, v_addr=479, valid_i=1 -> char_addr=2399 one cycle later. After char_data=16'h0041 is returned, font_addr = 12'h41F one cycle after that.
- Pixel decode: font_data=8'b1000_0001 with px=0 and px=7 -> vga_data=FG_COLOR; px=3 -> BG_COLOR. Each appears exactly 4 cycles after its h_addr.
- Sync alignment: toggle hsync_i/vsync_i/valid_i with a known pattern -> hsync_o/vsync_o/valid_o reproduce the pattern delayed exactly 4 cycles. With valid_i=0 and font_data=8'hFF -> vga_data=0.
- Cursor blink: BLINK_FRAMES=2, cur_x=5, cur_y=3, glyph rows 14/15 with font_data=0:
  - Frames 0-1 -> FG at h_addr 40..47.
  - Frames 2-3 -> BG at h_addr 40..47.
  - Rows 0..13 are never inverted.
- Reset mid-frame: assert reset_n=0 during active video -> vga_data=0, hsync_o=1, vsync_o=1, valid_o=0, char_addr=0 immediately without a clock edge. After release, the first correct pixel appears 4 cycles after the first valid input.
- With VGA_TEXT_ATTR_COLOR_EN: char_data=16'h1E41 -> set pixels FFFF55, clear pixels 0000AA.

Source files
------------

// File: rtl/vga_text_render.sv
`default_nettype none
// ============================================================================
// vga_text_render : 80x30 text-mode pixel source, 8x16 glyphs, 4-cycle latency
// Optional macro  : VGA_TEXT_ATTR_COLOR_EN (per-character CGA fg/bg attributes)
// Revision        : 1.0
// ============================================================================
module vga_text_render #(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] FG_COLOR     = 24'hAAAAAA,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [6:0]  cur_x,
  input  logic [4:0]  cur_y,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        valid_o,
  output logic [23:0] vga_data
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [6:0]  col;
  logic [4:0]  row;
  logic        frame_start;
  logic        inv;
  logic [23:0] fg_c, bg_c;

  // S1
  logic [11:0] char_addr_q, char_addr_d;
  logic [3:0]  glyph_row1_q, glyph_row1_d;
  logic [2:0]  px1_q, px1_d;
  logic        hit1_q, hit1_d, valid1_q, valid1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // S2
  logic [11:0] font_addr_q, font_addr_d;
  logic [2:0]  px2_q, px2_d;
  logic        cur2_q, cur2_d, valid2_q, valid2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  // S3
  logic        bit3_q, bit3_d, cur3_q, cur3_d, valid3_q, valid3_d, hs3_q, hs3_d, vs3_q, vs3_d;
  // S4
  logic [23:0] vga_data_q, vga_data_d;
  logic        valid4_q, valid4_d, hs4_q, hs4_d, vs4_q, vs4_d;
  // Blink
  logic        vs_prev_q, vs_prev_d, blink_on_q, blink_on_d;
  logic [7:0]  cnt_q, cnt_d;

`ifdef VGA_TEXT_ATTR_COLOR_EN
  logic [7:0] attr2_q, attr2_d;
  logic [3:0] fg_idx3_q, fg_idx3_d, bg_idx3_q, bg_idx3_d;
  logic       unused_ok;

  function automatic logic [23:0] cga(input logic [3:0] idx);
    case (idx)
      4'd0:    cga = 24'h000000;
      4'd1:    cga = 24'h0000AA;
      4'd2:    cga = 24'h00AA00;
      4'd3:    cga = 24'h00AAAA;
      4'd4:    cga = 24'hAA0000;
      4'd5:    cga = 24'hAA00AA;
      4'd6:    cga = 24'hAA5500;
      4'd7:    cga = 24'hAAAAAA;
      4'd8:    cga = 24'h555555;
      4'd9:    cga = 24'h5555FF;
      4'd10:   cga = 24'h55FF55;
      4'd11:   cga = 24'h55FFFF;
      4'd12:   cga = 24'hFF5555;
      4'd13:   cga = 24'hFF55FF;
      4'd14:   cga = 24'hFFFF55;
      default: cga = 24'hFFFFFF;
    endcase
  endfunction

  assign attr2_d   = char_data[15:8];
  assign fg_idx3_d = attr2_q[3:0];
  assign bg_idx3_d = attr2_q[7:4];
  assign fg_c      = cga(fg_idx3_q);
  assign bg_c      = cga(bg_idx3_q);
  assign unused_ok = v_addr[9];
`else
  logic unused_ok;
  assign fg_c      = FG_COLOR;
  assign bg_c      = BG_COLOR;
  assign unused_ok = ^{v_addr[9], char_data[15:8]};
`endif

  assign col         = h_addr[9:3];
  assign row         = v_addr[8:4];
  assign frame_start = vsync_i & ~vs_prev_q;
  // Cursor occupies only the bottom two glyph rows of its cell.
  assign inv         = cur3_q & blink_on_q;

  always_comb begin
    char_addr_d  = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    glyph_row1_d = v_addr[3:0];
    px1_d        = h_addr[2:0];
    hit1_d       = (col == cur_x) && (row == cur_y);
    valid1_d     = valid_i;
    hs1_d        = hsync_i;
    vs1_d        = vsync_i;

    font_addr_d  = {char_data[7:0], glyph_row1_q};
    px2_d        = px1_q;
    cur2_d       = hit1_q && (glyph_row1_q >= 4'd14);
    valid2_d     = valid1_q;
    hs2_d        = hs1_q;
    vs2_d        = vs1_q;

    bit3_d       = font_data[3'd7 - px2_q];
    cur3_d       = cur2_q;
    valid3_d     = valid2_q;
    hs3_d        = hs2_q;
    vs3_d        = vs2_q;

    vga_data_d   = valid3_q ? ((bit3_q ^ inv) ? fg_c : bg_c) : 24'h000000;
    valid4_d     = valid3_q;
    hs4_d        = hs3_q;
    vs4_d        = vs3_q;

    vs_prev_d    = vsync_i;
    cnt_d        = cnt_q;
    blink_on_d   = blink_on_q;
    if (frame_start) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d      = 8'd0;
        blink_on_d = ~blink_on_q;
      end else begin
        cnt_d      = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      char_addr_q  <= 12'd0;
      glyph_row1_q <= 4'd0;
      px1_q        <= 3'd0;
      hit1_q       <= 1'b0;
      valid1_q     <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      font_addr_q  <= 12'd0;
      px2_q        <= 3'd0;
      cur2_q       <= 1'b0;
      valid2_q     <= 1'b0;
      hs2_q        <= 1'b1;
      vs2_q        <= 1'b1;
      bit3_q       <= 1'b0;
      cur3_q       <= 1'b0;
      valid3_q     <= 1'b0;
      hs3_q        <= 1'b1;
      vs3_q        <= 1'b1;
      vga_data_q   <= 24'd0;
      valid4_q     <= 1'b0;
      hs4_q        <= 1'b1;
      vs4_q        <= 1'b1;
      vs_prev_q    <= 1'b1;
      cnt_q        <= 8'd0;
      blink_on_q   <= 1'b1;
`ifdef VGA_TEXT_ATTR_COLOR_EN
      attr2_q      <= 8'd0;
      fg_idx3_q    <= 4'd0;
      bg_idx3_q    <= 4'd0;
`endif
    end else begin
      char_addr_q  <= char_addr_d;
      glyph_row1_q <= glyph_row1_d;
      px1_q        <= px1_d;
      hit1_q       <= hit1_d;
      valid1_q     <= valid1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      font_addr_q  <= font_addr_d;
      px2_q        <= px2_d;
      cur2_q       <= cur2_d;
      valid2_q     <= valid2_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      bit3_q       <= bit3_d;
      cur3_q       <= cur3_d;
      valid3_q     <= valid3_d;
      hs3_q        <= hs3_d;
      vs3_q        <= vs3_d;
      vga_data_q   <= vga_data_d;
      valid4_q     <= valid4_d;
      hs4_q        <= hs4_d;
      vs4_q        <= vs4_d;
      vs_prev_q    <= vs_prev_d;
      cnt_q        <= cnt_d;
      blink_on_q   <= blink_on_d;
`ifdef VGA_TEXT_ATTR_COLOR_EN
      attr2_q      <= attr2_d;
      fg_idx3_q    <= fg_idx3_d;
      bg_idx3_q    <= bg_idx3_d;
`endif
    end
  end

  assign char_addr = char_addr_q;
  assign font_addr = font_addr_q;
  assign vga_data  = vga_data_q;
  assign valid_o   = valid4_q;
  assign hsync_o   = hs4_q;
  assign vsync_o   = vs4_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_render.sv
`default_nettype none
// ============================================================================
// tb_vga_text_render : directed self-checking bench for vga_text_render
// Revision           : 1.0
// ============================================================================
module tb_vga_text_render;

  localparam logic [23:0] FG = 24'hAAAAAA;
  localparam logic [23:0] BG = 24'h000000;
`ifdef VGA_TEXT_ATTR_COLOR_EN
  localparam logic [7:0] BASE_ATTR = 8'h07;
`else
  localparam logic [7:0] BASE_ATTR = 8'h00;
`endif

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_addr, v_addr;
  logic        valid_i, hsync_i, vsync_i;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic [11:0] char_addr, font_addr;
  logic [15:0] char_data;
  logic [7:0]  font_data;
  logic        hsync_o, vsync_o, valid_o;
  logic [23:0] vga_data;

  int total = 0;
  int bad   = 0;
  int ncnt  = 0;

  typedef struct {
    int          due;
    string       tag;
    logic [23:0] d;
    logic        v;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t q[$];

  always #5 pclk = ~pclk;

  vga_text_render #(.BLINK_FRAMES(2)) dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .h_addr    (h_addr),
    .v_addr    (v_addr),
    .valid_i   (valid_i),
    .hsync_i   (hsync_i),
    .vsync_i   (vsync_i),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .char_addr (char_addr),
    .char_data (char_data),
    .font_addr (font_addr),
    .font_data (font_data),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .valid_o   (valid_o),
    .vga_data  (vga_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One pixel clock: check outputs due now, then drive new inputs whose
  // results are expected four negedges later.
  task automatic cyc(input string tag, input logic [9:0] h, input logic [9:0] v,
                     input logic val, input logic hs, input logic vs, input logic [23:0] ed);
    exp_t e;
    @(negedge pclk);
    ncnt++;
    while (q.size() > 0 && q[0].due == ncnt) begin
      check({q[0].tag, "_data"},  {8'h0, vga_data}, {8'h0, q[0].d});
      check({q[0].tag, "_valid"}, {31'h0, valid_o}, {31'h0, q[0].v});
      check({q[0].tag, "_hs"},    {31'h0, hsync_o}, {31'h0, q[0].hs});
      check({q[0].tag, "_vs"},    {31'h0, vsync_o}, {31'h0, q[0].vs});
      void'(q.pop_front());
    end
    h_addr  = h;
    v_addr  = v;
    valid_i = val;
    hsync_i = hs;
    vsync_i = vs;
    e.due = ncnt + 4; e.tag = tag; e.d = ed; e.v = val; e.hs = hs; e.vs = vs;
    q.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic frame_pulse();
    drain(4);
    cyc("vs_lo", 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 24'h0);
    cyc("vs_hi", 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    h_addr    = 10'd0;
    v_addr    = 10'd0;
    valid_i   = 1'b0;
    hsync_i   = 1'b1;
    vsync_i   = 1'b1;
    cur_x     = 7'd5;
    cur_y     = 5'd3;
    char_data = {BASE_ATTR, 8'h41};
    font_data = 8'h81;

    repeat (3) @(negedge pclk);
    check("rst_char_addr", {20'h0, char_addr}, 32'd0);
    check("rst_font_addr", {20'h0, font_addr}, 32'd0);
    check("rst_vga_data",  {8'h0, vga_data},   32'd0);
    check("rst_valid_o",   {31'h0, valid_o},   32'd0);
    check("rst_hsync_o",   {31'h0, hsync_o},   32'd1);
    check("rst_vsync_o",   {31'h0, vsync_o},   32'd1);
    reset_n = 1'b1;

    // Address generation at the bottom-right corner
    @(negedge pclk);
    h_addr = 10'd639; v_addr = 10'd479; valid_i = 1'b1;
    @(negedge pclk);
    check("addr_char", {20'h0, char_addr}, 32'd2399);
    h_addr = 10'd0; v_addr = 10'd0; valid_i = 1'b0;
    @(negedge pclk);
    check("addr_font", {20'h0, font_addr}, 32'h41F);

    // Pixel decode with font row 1000_0001
    drain(4);
    cyc("px0",  10'd0, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    cyc("px7",  10'd7, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    cyc("px3",  10'd3, 10'd0, 1'b1, 1'b1, 1'b1, BG);
    cyc("px8",  10'd8, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    cyc("px14", 10'd14, 10'd0, 1'b1, 1'b1, 1'b1, BG);
    drain(4);

    // Sync alignment and blanking with a fully set font row
    font_data = 8'hFF;
    drain(4);
    cyc("blank", 10'd0,   10'd0,   1'b0, 1'b1, 1'b1, 24'h0);
    cyc("oob",   10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 24'h0);
    cyc("syn0",  10'd0, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    cyc("syn1",  10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0);
    cyc("syn2",  10'd0, 10'd0, 1'b1, 1'b0, 1'b0, FG);
    cyc("syn3",  10'd0, 10'd0, 1'b1, 1'b1, 1'b0, FG);
    cyc("syn4",  10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
    cyc("syn5",  10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0);
    cyc("syn6",  10'd0, 10'd0, 1'b1, 1'b1, 1'b0, FG);

    // Reset asserted mid-stream, checked between clock edges
    for (int i = 0; i < 6; i++) cyc("pre_rst", 10'd8, 10'd16, 1'b1, 1'b0, 1'b0, FG);
    @(negedge pclk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_vga_data",  {8'h0, vga_data},   32'd0);
    check("mid_rst_hsync_o",   {31'h0, hsync_o},   32'd1);
    check("mid_rst_vsync_o",   {31'h0, vsync_o},   32'd1);
    check("mid_rst_valid_o",   {31'h0, valid_o},   32'd0);
    check("mid_rst_char_addr", {20'h0, char_addr}, 32'd0);
    q.delete();
    h_addr = 10'd0; v_addr = 10'd0; valid_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
    cyc("post_rst0", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    cyc("post_rst1", 10'd5, 10'd0, 1'b1, 1'b1, 1'b1, FG);
    drain(4);

    // Cursor blink, BLINK_FRAMES=2, cursor at column 5 row 3
    font_data = 8'h00;
    drain(4);
    cyc("f0_r14_h40", 10'd40, 10'd62, 1'b1, 1'b1, 1'b1, FG);
    cyc("f0_r14_h47", 10'd47, 10'd62, 1'b1, 1'b1, 1'b1, FG);
    cyc("f0_r15_h40", 10'd40, 10'd63, 1'b1, 1'b1, 1'b1, FG);
    cyc("f0_r13_h44", 10'd44, 10'd61, 1'b1, 1'b1, 1'b1, BG);
    cyc("f0_r0_h44",  10'd44, 10'd48, 1'b1, 1'b1, 1'b1, BG);
    cyc("f0_r14_h48", 10'd48, 10'd62, 1'b1, 1'b1, 1'b1, BG);
    cyc("f0_r14_h39", 10'd39, 10'd62, 1'b1, 1'b1, 1'b1, BG);
    frame_pulse();
    cyc("f1_r15_h43", 10'd43, 10'd63, 1'b1, 1'b1, 1'b1, FG);
    frame_pulse();
    cyc("f2_r14_h40", 10'd40, 10'd62, 1'b1, 1'b1, 1'b1, BG);
    cyc("f2_r15_h47", 10'd47, 10'd63, 1'b1, 1'b1, 1'b1, BG);
    frame_pulse();
    cyc("f3_r14_h44", 10'd44, 10'd62, 1'b1, 1'b1, 1'b1, BG);
    frame_pulse();
    cyc("f4_r14_h44", 10'd44, 10'd62, 1'b1, 1'b1, 1'b1, FG);
    cyc("f4_r13_h44", 10'd44, 10'd61, 1'b1, 1'b1, 1'b1, BG);
    drain(4);

`ifdef VGA_TEXT_ATTR_COLOR_EN
    // Per-character colours: fg index 14, bg index 1
    char_data = 16'h1E41;
    font_data = 8'h81;
    drain(4);
    cyc("attr_set", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 24'hFFFF55);
    cyc("attr_clr", 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 24'h0000AA);
    drain(4);
`endif

    drain(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
